mlp_neuron_seq: RTL and testbench

//  Sequencer for the 4b x 4b signed MAC + ReLU neuron datapath. Latches a bias and a term count.

---
 rtl/mlp_neuron_seq.sv | 138 +++++++++++++
 tb/tb_mlp_neuron_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_neuron_seq.sv
// Sequencer for a 4b x 4b signed MAC + ReLU neuron: latches bias and term count, accumulates
// LEN streamed (input, weight) products, then holds the total on a valid/ready result port.
module mlp_neuron_seq #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN_W = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] cfg_bias,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_i,
  input  logic [3:0]       in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_raw,
  output logic [ACC_W-1:0] out_relu,
  output logic             busy,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid come from registered state only; valid is never withdrawn
  // by this block once raised, and the result is held until taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             beat;
  logic             last_beat;
  logic             accept_start;
  logic signed [7:0] prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_now;
  logic [ACC_W-1:0] sat_val;

  assign accept_start = (state == S_IDLE) && start;
  assign beat         = (state == S_ACC) && in_valid;
  assign last_beat    = beat && (cnt == (len_q - 1'b1));

  assign prod     = $signed(in_i) * $signed(in_w);
  assign prod_ext = {{(ACC_W-8){prod[7]}}, prod};
  assign sum      = acc + prod_ext;
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign sat_val  = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_len != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Accumulator datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      len_q <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (accept_start) begin
      acc   <= cfg_bias;
      len_q <= cfg_len;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (beat) begin
      cnt <= cnt + 1'b1;
      if (ovf_now) begin
        ovf <= 1'b1;
      end
      acc <= (SAT && ovf_now) ? sat_val : sum;
    end
  end

  assign out_raw   = acc;
  assign out_relu  = (!acc[ACC_W-1] && (acc != '0)) ? acc : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_mlp_neuron_seq.sv
// Bench for mlp_neuron_seq: wrapping and saturating instances share stimulus and are
// checked against an integer-arithmetic neuron model.
module tb_mlp_neuron_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_bias;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [3:0]  in_i;
  logic [3:0]  in_w;
  logic        out_ready;

  logic        in_ready, out_valid, busy, ovf;
  logic [15:0] out_raw, out_relu;
  logic [1:0]  state_dbg;
  logic        s_in_ready, s_out_valid, s_busy, s_ovf;
  logic [15:0] s_out_raw, s_out_relu;
  logic [1:0]  s_state_dbg;

  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [3:0]  pi [256];
  logic [3:0]  pw [256];
  logic [15:0] exp_q [$];

  mlp_neuron_seq #(.ACC_W(16), .LEN_W(8), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bias(cfg_bias), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_raw(out_raw), .out_relu(out_relu),
    .busy(busy), .ovf(ovf), .state_dbg(state_dbg)
  );

  mlp_neuron_seq #(.ACC_W(16), .LEN_W(8), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_bias(cfg_bias), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_i(in_i), .in_w(in_w),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_raw(s_out_raw), .out_relu(s_out_relu),
    .busy(s_busy), .ovf(s_ovf), .state_dbg(s_state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nib(input logic [3:0] n);
    return n[3] ? int'(n) - 16 : int'(n);
  endfunction

  // Reference: bias plus sum of signed products, with range handling at each step.
  function automatic void model(input logic [15:0] bias, input int len, input bit sat,
                                output logic [15:0] raw, output bit ov);
    int a;
    a  = int'($signed(bias));
    ov = 1'b0;
    for (int k = 0; k < len; k++) begin
      a = a + nib(pi[k]) * nib(pw[k]);
      if (a > 32767) begin
        ov = 1'b1;
        a  = sat ? 32767 : a - 65536;
      end else if (a < -32768) begin
        ov = 1'b1;
        a  = sat ? -32768 : a + 65536;
      end
    end
    raw = a[15:0];
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] r);
    return ($signed(r) > 0) ? r : 16'h0000;
  endfunction

  task automatic run_eval(input logic [15:0] bias, input int len, input int vprob,
                          input int stall, input bit noise);
    logic [15:0] raw_w, raw_s, exp_w;
    bit          ov_w, ov_s;
    int          idx, guard, c0;
    logic        rdy;
    model(bias, len, 1'b0, raw_w, ov_w);
    model(bias, len, 1'b1, raw_s, ov_s);
    exp_q.push_back(raw_w);

    @(negedge clk);
    start = 1'b1; cfg_bias = bias; cfg_len = 8'(len); c0 = cyc;
    @(posedge clk);
    idx = 0; guard = 0;
    while (idx < len && guard < 2000) begin
      @(negedge clk);
      guard++;
      rdy      = in_ready;
      in_valid = ($urandom_range(0, 99) < vprob);
      in_i     = pi[idx];
      in_w     = pw[idx];
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        cfg_bias = 16'($urandom); cfg_len = 8'($urandom);
      end
      @(posedge clk);
      if (in_valid && rdy) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    if (len == 0) check("len0_in_ready", in_ready, 1'b0);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_seen", out_valid, 1'b1);
    if (!out_valid) return;
    if (vprob == 100) check("latency", cyc - c0, len + 1);

    exp_w = exp_q.pop_front();
    check("raw_wrap", out_raw, exp_w);
    check("relu_wrap", out_relu, relu(exp_w));
    check("ovf_wrap", ovf, ov_w);
    check("raw_sat", s_out_raw, raw_s);
    check("relu_sat", s_out_relu, relu(raw_s));
    check("ovf_sat", s_ovf, ov_s);
    check("busy_done", busy, 1'b1);
    check("in_ready_done", in_ready, 1'b0);

    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_i      = 4'($urandom); in_w = 4'($urandom);
      start     = noise;
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_raw", out_raw, exp_w);
      check("stall_raw_sat", s_out_raw, raw_s);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_result", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic set_pair(input int k, input logic [3:0] i, input logic [3:0] w);
    pi[k] = i; pw[k] = w;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; cfg_bias = '0; cfg_len = '0;
    in_valid = 1'b0; in_i = '0; in_w = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_raw", out_raw, 16'h0000);
    check("rst_relu", out_relu, 16'h0000);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // T1
    set_pair(0, 4'h3, 4'h2); set_pair(1, 4'hF, 4'h4); set_pair(2, 4'h7, 4'h7);
    run_eval(16'h0000, 3, 100, 0, 1'b0);
    // T2
    set_pair(0, 4'h2, 4'h3);
    run_eval(16'hFFF6, 1, 100, 0, 1'b0);
    // T3
    run_eval(16'h0005, 0, 100, 0, 1'b0);
    // T4 positive overflow
    set_pair(0, 4'h7, 4'h7);
    run_eval(16'h7FF0, 1, 100, 0, 1'b0);
    // Negative overflow, extreme products, zero result
    set_pair(0, 4'h8, 4'h7);
    run_eval(16'h8000, 1, 100, 0, 1'b0);
    set_pair(0, 4'h8, 4'h8); set_pair(1, 4'h8, 4'h7);
    run_eval(16'h0000, 2, 100, 0, 1'b0);
    set_pair(0, 4'h0, 4'h5);
    run_eval(16'h0000, 1, 100, 0, 1'b0);
    run_eval(16'h8000, 0, 100, 0, 1'b0);

    // T6: reset after 2 of 4 beats
    set_pair(0, 4'h1, 4'h1); set_pair(1, 4'h2, 4'h2);
    @(negedge clk);
    start = 1'b1; cfg_bias = 16'h1234; cfg_len = 8'd4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_i = pi[k]; in_w = pw[k];
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_raw", out_raw, 16'h0000);
    check("t6_ovf", ovf, 1'b0);
    check("t6_in_ready", in_ready, 1'b0);
    set_pair(0, 4'h3, 4'h2); set_pair(1, 4'hF, 4'h4); set_pair(2, 4'h7, 4'h7);
    run_eval(16'h0000, 3, 100, 0, 1'b0);

    // T5 and randomized evaluations
    for (int t = 0; t < 40; t++) begin
      int          len;
      logic [15:0] bias;
      len = $urandom_range(0, 24);
      for (int k = 0; k < len; k++) set_pair(k, 4'($urandom), 4'($urandom));
      case ($urandom_range(0, 3))
        0:       bias = 16'h7F00 + 16'($urandom_range(0, 255));
        1:       bias = 16'h8000 + 16'($urandom_range(0, 255));
        default: bias = 16'($urandom);
      endcase
      run_eval(bias, len, (t % 2 == 0) ? 50 : 100, (t % 3 == 0) ? 5 : $urandom_range(0, 2),
               (t % 4 == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
